// File: rtl/rx_bit_timer.sv
// UART receive bit timer: while enable_timer is held, issues one shift_strobe per
// bit at the bit centre and flags packet_done on the strobe that captures the stop bit.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIRST_DELAY  = 14,
  parameter int FRAME_BITS   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_timer,
  output logic       shift_strobe,
  output logic       packet_done,
  output logic [3:0] bit_index,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALIGN     = 2'd1,
    BIT       = 2'd2,
    DONE_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] FIRST_LOAD = 8'(FIRST_DELAY - 1);
  localparam logic [7:0] BIT_LOAD   = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_IDX   = 4'(FRAME_BITS);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic       strobe_q, strobe_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 4'd0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // Dropping enable in ALIGN/BIT wins over a strobe due on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 4'd0;
        if (enable_timer) begin
          state_d = ALIGN;
          cnt_d   = FIRST_LOAD;
        end
      end
      ALIGN: begin
        if (!enable_timer) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          idx_d   = 4'd0;
        end else if (cnt_q == 8'd0) begin
          idx_d   = 4'd1;
          cnt_d   = BIT_LOAD;
          state_d = (LAST_IDX == 4'd1) ? DONE_HOLD : BIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BIT: begin
        if (!enable_timer) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          idx_d   = 4'd0;
        end else if (cnt_q == 8'd0) begin
          idx_d = idx_q + 4'd1;
          cnt_d = BIT_LOAD;
          if ((idx_q + 4'd1) == LAST_IDX) begin
            state_d = DONE_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE_HOLD: begin
        if (!enable_timer) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          idx_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    strobe_d = 1'b0;
    done_d   = 1'b0;
    if (enable_timer && (cnt_q == 8'd0)) begin
      if (state_q == ALIGN) begin
        strobe_d = 1'b1;
        done_d   = (LAST_IDX == 4'd1);
      end else if (state_q == BIT) begin
        strobe_d = 1'b1;
        done_d   = ((idx_q + 4'd1) == LAST_IDX);
      end
    end
  end

  assign shift_strobe = strobe_q;
  assign packet_done  = done_q;
  assign bit_index    = idx_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: a default-parameter and a corner-parameter instance, frames
// described by enable/reset timing, expected strobes derived arithmetically from E0.
module tb_rx_bit_timer;

  localparam int W = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0, en0, sb0, pd0;
  logic [3:0] bi0;
  logic [1:0] st0;
  logic       rst1, en1, sb1, pd1;
  logic [3:0] bi1;
  logic [1:0] st1;

  int fd_a[2]  = '{14, 1};
  int cpb_a[2] = '{10, 2};
  int fb_a[2]  = '{9, 1};

  rx_bit_timer #(.CLKS_PER_BIT(10), .FIRST_DELAY(14), .FRAME_BITS(9)) u_dut0 (
    .clk(clk), .rst(rst0), .enable_timer(en0),
    .shift_strobe(sb0), .packet_done(pd0), .bit_index(bi0), .dbg_state(st0)
  );

  rx_bit_timer #(.CLKS_PER_BIT(2), .FIRST_DELAY(1), .FRAME_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst1), .enable_timer(en1),
    .shift_strobe(sb1), .packet_done(pd1), .bit_index(bi1), .dbg_state(st1)
  );

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Pulse record: edge number, bit_index, strobe, packet_done.
  function automatic logic [W-1:0] pack(input int edge_n, input int idx, input logic strobe,
                                        input logic done);
    return {16'(edge_n), 4'(idx), strobe, done};
  endfunction

  function automatic int exp_idx(input int base, input int n, input int d);
    int k;
    if (n < base + fd_a[d]) return 0;
    k = (n - base - fd_a[d]) / cpb_a[d] + 1;
    return (k > fb_a[d]) ? fb_a[d] : k;
  endfunction

  task automatic push_exp(input int d, input logic [W-1:0] v);
    if (d == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic set_in(input int d, input logic en, input logic r);
    if (d == 0) begin
      en0  = en;
      rst0 = r;
    end else begin
      en1  = en;
      rst1 = r;
    end
  endtask

  function automatic int get_idx(input int d);
    return (d == 0) ? int'(bi0) : int'(bi1);
  endfunction

  // Monitors: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sb0 || pd0) begin
      if (exp_q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected_pulse at edge %0d: got strobe=%0b done=%0b idx=%0d required none",
                 cyc, sb0, pd0, bi0);
      end else begin
        check("dut0_pulse", int'(pack(cyc, int'(bi0), sb0, pd0)), int'(exp_q0.pop_front()));
      end
    end
    if (sb1 || pd1) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_pulse at edge %0d: got strobe=%0b done=%0b idx=%0d required none",
                 cyc, sb1, pd1, bi1);
      end else begin
        check("dut1_pulse", int'(pack(cyc, int'(bi1), sb1, pd1)), int'(exp_q1.pop_front()));
      end
    end
  end

  // Holds enable for 'hold' sampled edges starting at E0; optional one-clock reset at
  // E0+rst_off (must satisfy 1 <= rst_off < hold-1). Ends one edge after enable falls.
  task automatic run_frame(input int d, input int hold, input int rst_off);
    int e0, dd, r, base, e;
    e0 = cyc + 1;
    dd = e0 + hold;
    r  = (rst_off > 0) ? e0 + rst_off : -1;
    for (int k = 1; k <= fb_a[d]; k++) begin
      e = e0 + fd_a[d] + (k - 1) * cpb_a[d];
      if (e < dd && (r < 0 || e < r)) push_exp(d, pack(e, k, 1'b1, k == fb_a[d]));
    end
    if (r > 0) begin
      for (int k = 1; k <= fb_a[d]; k++) begin
        e = r + 1 + fd_a[d] + (k - 1) * cpb_a[d];
        if (e < dd) push_exp(d, pack(e, k, 1'b1, k == fb_a[d]));
      end
    end
    set_in(d, 1'b1, 1'b0);
    base = e0;
    while (cyc < dd - 1) begin
      @(negedge clk);
      set_in(d, 1'b1, (r > 0) && (cyc == r - 1));
      if (r > 0 && cyc == r) begin
        check("bit_index_after_rst", get_idx(d), 0);
      end else begin
        if (r > 0 && cyc > r) base = r + 1;
        check("bit_index", get_idx(d), exp_idx(base, cyc, d));
      end
    end
    set_in(d, 1'b0, 1'b0);
    @(negedge clk);
    check("bit_index_after_drop", get_idx(d), 0);
  endtask

  initial begin
    int hold, roff;
    rst0 = 1'b1;
    rst1 = 1'b1;
    en0  = 1'b0;
    en1  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_strobe0", int'(sb0), 0);
    check("rst_done0", int'(pd0), 0);
    check("rst_idx0", int'(bi0), 0);
    check("rst_state0", int'(st0), 0);
    check("rst_strobe1", int'(sb1), 0);
    check("rst_done1", int'(pd1), 0);
    check("rst_idx1", int'(bi1), 0);
    check("rst_state1", int'(st1), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Default frame, then aborts after strobe 4 and exactly on strobe 5's edge.
    run_frame(0, 120, 0);
    repeat (3) @(negedge clk);
    run_frame(0, 45, 0);
    repeat (100) @(negedge clk);
    run_frame(0, 54, 0);
    repeat (3) @(negedge clk);
    // Reset at E0+50 with enable high, frame restarts after release.
    run_frame(0, 160, 50);
    repeat (3) @(negedge clk);
    // Back-to-back: one low edge after packet_done, second frame lingers in DONE_HOLD.
    run_frame(0, 95, 0);
    run_frame(0, 145, 0);
    repeat (3) @(negedge clk);

    // Corner instance: single strobe at E0+1.
    run_frame(1, 20, 0);
    run_frame(1, 2, 0);
    repeat (2) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        hold = int'($urandom_range(1, 130));
        roff = 0;
        if (hold > 4 && $urandom_range(0, 2) == 0) roff = int'($urandom_range(1, hold - 2));
        run_frame(d, hold, roff);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    check("dut0_queue_empty", exp_q0.size(), 0);
    check("dut1_queue_empty", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

UART receive bit timer for the serial receiver datapath. It is enabled by the receiver control unit's `enable_timer`. While enabled, it produces one `shift_strobe` pulse per bit at the bit-centre sample point to clock the 9-bit receive shift register. It returns `packet_done` to the control unit on the strobe that captures the stop bit.

## Interface
- `CLKS_PER_BIT`, default 10: clocks per serial bit; legal range 2..255.
- `FIRST_DELAY`, default 14: clocks from enable sampled high to the first data-bit strobe (start-bit remainder plus half a bit); legal range 1..255.
- `FRAME_BITS`, default 9: strobes per frame (8 data + 1 stop); legal range 1..15.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, synchronous active-high reset.
- `enable_timer`  in  1  run request from receiver control unit; level-sensitive.
- `shift_strobe`  out  1  one-clock pulse; shift register samples serial_in.
- `packet_done`  out  1  one-clock pulse coincident with the FRAME_BITS-th strobe.
- `bit_index`  out  4  strobes issued in the current frame, 0..FRAME_BITS.

## Operation
- All outputs are registered. On reset: `shift_strobe=0`, `packet_done=0`, `bit_index=0`, state IDLE, counter=0.
- 8-bit down-counter `cnt`.
- FSM states:
  - **IDLE**: outputs 0, `bit_index=0`. If `enable_timer=1`, go to ALIGN with `cnt=FIRST_DELAY-1`.
  - **ALIGN**: when `cnt=0`, assert strobe, set `bit_index=1`, and load `cnt=CLKS_PER_BIT-1`. Next state is BIT, or DONE_HOLD if FRAME_BITS=1. Otherwise decrement.
  - **BIT**: when `cnt=0`, assert strobe, increment `bit_index`, and reload `cnt=CLKS_PER_BIT-1`. If the new `bit_index` equals FRAME_BITS, also assert `packet_done` and go to DONE_HOLD. Otherwise decrement.
  - **DONE_HOLD**: no strobes; `bit_index` holds FRAME_BITS. When `enable_timer=0`, go to IDLE. Covers the control unit's stop-bit and framing checks, where enable stays high.
- Enable dropped in ALIGN or BIT: at the next edge go to IDLE. Clear `cnt` and `bit_index`. Issue no strobe and no `packet_done`, even if `cnt=0` at that edge.
- Re-arming needs `enable_timer` low for at least one sampled edge. A frame never starts directly out of DONE_HOLD.
- `rst` has priority over every other condition, in every state.
- Arithmetic: `cnt` is 8-bit unsigned with no wrap. Reload values are computed at parameter width and truncated to 8 bits. Legal ranges guarantee no overflow.

## Timing
- Let E0 be the edge at which IDLE samples `enable_timer=1`.
- First strobe is high for the clock after edge E0+FIRST_DELAY.
- Strobe k (k=1..FRAME_BITS) follows edge E0+FIRST_DELAY+(k-1)*CLKS_PER_BIT.
- Defaults: strobes after edges E0+14, +24, … +94. `packet_done` and `bit_index=9` appear after edge E0+94.
- `shift_strobe` and `packet_done` are never high for two consecutive clocks.
- `packet_done` fires once per frame.
- `bit_index` updates on the same edge its strobe rises.
- Enable-drop response latency is 1 edge: outputs are 0 in the cycle after the edge that samples `enable_timer=0`.

## Test plan
- **Default frame**: reset, then hold enable high from E0 for 120 clocks.
  - Exactly 9 strobes, after edges E0+14, 24, …, 94.
  - `packet_done` only after E0+94.
  - `bit_index` steps 1..9, then holds 9 until enable falls.
  - After enable falls, `bit_index` returns to 0 one edge later.
- **Abort mid-frame**: drop enable at the edge after strobe 4 (`bit_index=4`).
  - Next cycle: `bit_index=0`.
  - No further strobes and no `packet_done` over 100 clocks.
- **Abort on strobe edge**: drop enable exactly at the edge where `cnt=0` in BIT.
  - No strobe emitted; IDLE next cycle.
- **Reset mid-frame**: assert `rst` for one clock at E0+50 with enable still high.
  - All outputs 0 the next cycle.
  - After `rst` releases, enable still high restarts a frame: first strobe 14 edges after the first edge with `rst` low.
- **Back-to-back frames**: enable low for exactly one edge after `packet_done`, then high again.
  - Second frame timing is identical to the first, relative to its own E0.
  - Enable held high through DONE_HOLD for 50 clocks produces no strobes.
- **Parameter corner**: CLKS_PER_BIT=2, FIRST_DELAY=1, FRAME_BITS=1.
  - Single strobe plus `packet_done` after edge E0+1.
  - Then DONE_HOLD until enable drops.
